ext_call_arbiter: RTL and testbench
===================================

Name: ext_call_arbiter

Overview:
Round-robin arbiter sharing one external-call module among NUM_REQ HLS-generated callers.
- Both sides use the req_valid/req_ready ext-call handshake; downstream also takes x/y arguments and returns a 1-bit z.
- Sits between the scheduled datapath's ext-task call sites and a single instance of the called module.
- Serialises calls, holds arguments stable, and routes z and ready back to the winning caller.

Parameters:
NUM_REQ, 2, number of callers (1..8)
DATA_WIDTH, 32, width of x and y
TIMEOUT_CYCLES, 255, watchdog limit; used only with ARB_TIMEOUT_EN

Ports:
clk  in  1  clock, all logic posedge
rst_n  in  1  reset, synchronous, active-low
req_valid  in  NUM_REQ  per-caller call request, held until its req_ready
req_ready  out  NUM_REQ  per-caller completion pulse, registered, 1 cycle
req_x  in  NUM_REQ*DATA_WIDTH  packed caller x; caller i at [i*DW +: DW]
req_y  in  NUM_REQ*DATA_WIDTH  packed caller y, same packing
req_z  out  NUM_REQ  per-caller result, registered, holds until that caller's next completion
m_req_valid  out  1  request to shared module
m_req_ready  in  1  completion from shared module
m_x  out  DATA_WIDTH  argument to shared module, registered
m_y  out  DATA_WIDTH  argument to shared module, registered
m_z  in  1  result from shared module
err_timeout  out  NUM_REQ  present only with ARB_TIMEOUT_EN; abort flag, pulses with req_ready

Behaviour:
Reset values:
- req_ready=0, req_z=0, m_req_valid=0, m_x=0, m_y=0.
- State=IDLE; last_grant=NUM_REQ-1, so caller 0 wins first.

IDLE:
- If any req_valid: g = first set bit scanning from last_grant+1 with wrap.
- Latch g; m_x/m_y <= caller g's x/y; m_req_valid <= 1; go to BUSY.
- No request: stay in IDLE, outputs unchanged.

BUSY:
- m_req_valid=1; m_x/m_y/g frozen.
- req_valid of any caller, including g, is ignored; a caller dropping req_valid does not cancel the committed call.
- On m_req_ready=1: req_z[g] <= m_z; req_ready[g] <= 1 for one cycle; m_req_valid <= 0; last_grant <= g; go to RELEASE.

RELEASE:
- One cycle; m_req_valid=0.
- m_req_ready is ignored: the downstream ready may lag one cycle.
- Caller g's req_valid is ignored; caller drops it on seeing req_ready.
- Go to IDLE; arbitration resumes next cycle.

Latency and throughput:
- Caller raises req_valid at cycle 0 -> m_req_valid=1 at cycle 1.
- With a downstream that registers ready (ready one cycle after valid), req_ready[g]=1 at cycle 3.
- Back-to-back calls: one call per 4 cycles minimum.

Boundary conditions:
- m_req_ready outside BUSY is ignored.
- All callers valid: strict rotation 0,1,..,NUM_REQ-1,0.
- NUM_REQ=1: always grants caller 0.
- Reset mid-BUSY: m_req_valid drops the next cycle; no req_ready pulse issued.

Optional Feature:
ARB_TIMEOUT_EN
- Defined: 16-bit counter cleared on BUSY entry, incremented each BUSY cycle.
- At TIMEOUT_CYCLES without m_req_ready: abort. req_ready[g]=1 and err_timeout[g]=1 (one cycle), req_z[g] unchanged, m_req_valid<=0, last_grant<=g, go to RELEASE.
- Undefined: no counter and no err_timeout port; BUSY waits indefinitely.

Decomposition:
- Package ext_arb_pkg: state enum (IDLE, BUSY, RELEASE), MAX_REQ=8, index-width constant/function, timeout counter width 16.
- One combinational sub-module, ext_arb_rr_pick: inputs request vector and last_grant; outputs any_valid and grant index.

Test Plan:
- Single call: caller0 valid, x=5, y=7; downstream ready one cycle after valid, m_z=1 -> m_x=5, m_y=7 at cycle 1; req_ready[0] pulse at cycle 3; req_z[0]=1.
- Contention: callers 0 and 1 valid together from reset -> grant order 0,1,0,1; each m_x matches its caller; no overlap of m_req_valid between calls.
- Lagging ready: downstream holds ready one extra cycle after valid drops -> no spurious second completion; exactly one req_ready pulse per call.
- Caller withdraws: caller1 drops req_valid in cycle 2 of BUSY -> call still completes; req_ready[1] pulses; req_z[1] updated.
- Reset mid-BUSY: rst_n low at cycle 2 -> all outputs 0 next cycle; caller 0 wins first after reset.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=10, downstream never ready -> err_timeout[g] and req_ready[g] pulse after 10 BUSY cycles; next caller granted after RELEASE.

Source files
------------

// File: rtl/ext_arb_pkg.sv
// Shared types and constants for the external-call arbiter.
// Optional watchdog is enabled with ARB_TIMEOUT_EN.
package ext_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RELEASE
    } arb_state_t;

    localparam int MAX_REQ = 8;
    localparam int TMO_W   = 16;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ext_arb_rr_pick.sv
// Combinational round-robin picker: first requester after i_last, wrapping.
module ext_arb_rr_pick
    import ext_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IW      = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_last,
    output logic               o_any,
    output logic [IW-1:0]      o_grant
);

    int w_dist;
    int w_best;

    assign o_any = |i_req;

    // Rank each caller by its distance past i_last; lowest ranked requester wins.
    always_comb begin
        o_grant = '0;
        w_best  = NUM_REQ;
        w_dist  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = (i + 2 * NUM_REQ - int'(i_last) - 1) % NUM_REQ;
            if (i_req[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                o_grant = IW'(i);
            end
        end
    end

endmodule

// File: rtl/ext_call_arbiter.sv
// Round-robin arbiter sharing one external-call module among NUM_REQ callers.
// Define ARB_TIMEOUT_EN to add the BUSY watchdog and err_timeout port.
module ext_call_arbiter
    import ext_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_x,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_y,
    output logic [NUM_REQ-1:0]            req_z,
    output logic                          m_req_valid,
    input  logic                          m_req_ready,
    output logic [DATA_WIDTH-1:0]         m_x,
    output logic [DATA_WIDTH-1:0]         m_y,
    input  logic                          m_z
`ifdef ARB_TIMEOUT_EN
    ,
    output logic [NUM_REQ-1:0]            err_timeout
`endif
);

    localparam int IW = idx_w(NUM_REQ);

    arb_state_t            r_state, w_state_nx;
    logic [IW-1:0]         r_grant, w_grant_nx;
    logic [IW-1:0]         r_last, w_last_nx;
    logic [IW-1:0]         w_pick;
    logic                  w_any;
    logic [NUM_REQ-1:0]    r_ready, w_ready_nx;
    logic [NUM_REQ-1:0]    r_z, w_z_nx;
    logic [NUM_REQ-1:0]    w_sel;
    logic                  r_mv, w_mv_nx;
    logic [DATA_WIDTH-1:0] r_mx, w_mx_nx;
    logic [DATA_WIDTH-1:0] r_my, w_my_nx;
    logic                  w_tmo;

`ifdef ARB_TIMEOUT_EN
    logic [TMO_W-1:0]      r_cnt, w_cnt_nx;
    logic [NUM_REQ-1:0]    r_err, w_err_nx;

    assign w_tmo       = (r_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign err_timeout = r_err;
`else
    assign w_tmo = 1'b0;
`endif

    ext_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .i_req   (req_valid),
        .i_last  (r_last),
        .o_any   (w_any),
        .o_grant (w_pick)
    );

    assign w_sel       = NUM_REQ'(1) << r_grant;
    assign req_ready   = r_ready;
    assign req_z       = r_z;
    assign m_req_valid = r_mv;
    assign m_x         = r_mx;
    assign m_y         = r_my;

    always_comb begin
        w_state_nx = r_state;
        w_grant_nx = r_grant;
        w_last_nx  = r_last;
        w_ready_nx = '0;
        w_z_nx     = r_z;
        w_mv_nx    = r_mv;
        w_mx_nx    = r_mx;
        w_my_nx    = r_my;
`ifdef ARB_TIMEOUT_EN
        w_cnt_nx   = r_cnt;
        w_err_nx   = '0;
`endif
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant_nx = w_pick;
                    w_mv_nx    = 1'b1;
                    w_state_nx = BUSY;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (w_pick == IW'(i)) begin
                            w_mx_nx = req_x[i*DATA_WIDTH +: DATA_WIDTH];
                            w_my_nx = req_y[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    w_cnt_nx = '0;
`endif
                end
            end
            BUSY: begin
`ifdef ARB_TIMEOUT_EN
                w_cnt_nx = r_cnt + 1'b1;
`endif
                if (m_req_ready) begin
                    w_z_nx     = (r_z & ~w_sel) | (w_sel & {NUM_REQ{m_z}});
                    w_ready_nx = w_sel;
                    w_mv_nx    = 1'b0;
                    w_last_nx  = r_grant;
                    w_state_nx = RELEASE;
                end else if (w_tmo) begin
                    // Abort: complete the caller without touching its result.
                    w_ready_nx = w_sel;
                    w_mv_nx    = 1'b0;
                    w_last_nx  = r_grant;
                    w_state_nx = RELEASE;
`ifdef ARB_TIMEOUT_EN
                    w_err_nx   = w_sel;
`endif
                end
            end
            RELEASE: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= IW'(NUM_REQ - 1);
            r_ready <= '0;
            r_z     <= '0;
            r_mv    <= 1'b0;
            r_mx    <= '0;
            r_my    <= '0;
`ifdef ARB_TIMEOUT_EN
            r_cnt   <= '0;
            r_err   <= '0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_grant <= w_grant_nx;
            r_last  <= w_last_nx;
            r_ready <= w_ready_nx;
            r_z     <= w_z_nx;
            r_mv    <= w_mv_nx;
            r_mx    <= w_mx_nx;
            r_my    <= w_my_nx;
`ifdef ARB_TIMEOUT_EN
            r_cnt   <= w_cnt_nx;
            r_err   <= w_err_nx;
`endif
        end
    end

endmodule

// File: tb/tb_ext_call_arbiter.sv
// Directed bench for ext_call_arbiter with a transaction-level reference model.
// Covers the ARB_TIMEOUT_EN watchdog when that macro is defined.
module tb_ext_call_arbiter;

    localparam int N  = 2;
    localparam int DW = 32;
`ifdef ARB_TIMEOUT_EN
    localparam int TMO    = 10;
    localparam bit TMO_ON = 1'b1;
`else
    localparam int TMO    = 255;
    localparam bit TMO_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_x;
    logic [N*DW-1:0] req_y;
    logic [N-1:0]    req_z;
    logic            m_req_valid;
    logic            m_req_ready;
    logic [DW-1:0]   m_x;
    logic [DW-1:0]   m_y;
    logic            m_z;
    logic [N-1:0]    err_timeout;
    logic [DW-1:0]   cx [N];
    logic [DW-1:0]   cy [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_x[g*DW +: DW] = cx[g];
        assign req_y[g*DW +: DW] = cy[g];
    end

`ifndef ARB_TIMEOUT_EN
    assign err_timeout = '0;
`endif

    ext_call_arbiter #(
        .NUM_REQ        (N),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_z       (req_z),
        .m_req_valid (m_req_valid),
        .m_req_ready (m_req_ready),
        .m_x         (m_x),
        .m_y         (m_y),
        .m_z         (m_z)
`ifdef ARB_TIMEOUT_EN
        ,
        .err_timeout (err_timeout)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding call, a one-cycle gap after each
    // completion, then a fresh rotation starting after the last winner.
    int            m_cur;
    int            m_last;
    int            m_busy;
    int            m_c;
    bit            m_gap;
    logic [N-1:0]  e_ready, e_z, e_err;
    logic          e_mv;
    logic [DW-1:0] e_mx, e_my;
    int            grants[$];

    always @(posedge clk) begin
        e_ready = '0;
        e_err   = '0;
        if (!rst_n) begin
            m_cur  = -1;
            m_last = N - 1;
            m_gap  = 1'b0;
            m_busy = 0;
            e_z    = '0;
            e_mv   = 1'b0;
            e_mx   = '0;
            e_my   = '0;
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_cur < 0) begin
            for (int k = 1; k <= N; k++) begin
                m_c = (m_last + k) % N;
                if (m_cur < 0 && req_valid[m_c]) begin
                    m_cur  = m_c;
                    m_busy = 0;
                    e_mv   = 1'b1;
                    e_mx   = cx[m_c];
                    e_my   = cy[m_c];
                    grants.push_back(m_c);
                end
            end
        end else begin
            m_busy++;
            if (m_req_ready || (TMO_ON && m_busy == TMO)) begin
                if (m_req_ready) e_z[m_cur] = m_z;
                else e_err[m_cur] = 1'b1;
                e_ready[m_cur] = 1'b1;
                e_mv   = 1'b0;
                m_last = m_cur;
                m_cur  = -1;
                m_gap  = 1'b1;
            end
        end
    end

    // Callers, downstream responder and per-cycle comparison.
    bit chk_en = 1'b0;
    int dmode;
    bit zforce;
    bit seen, last_r, rr;
    int auto_left [N];
    int issued    [N];
    int pulses    [N];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 64'(req_ready), 64'(e_ready));
            chk("req_z", 64'(req_z), 64'(e_z));
            chk("m_req_valid", 64'(m_req_valid), 64'(e_mv));
            chk("m_x", 64'(m_x), 64'(e_mx));
            chk("m_y", 64'(m_y), 64'(e_my));
`ifdef ARB_TIMEOUT_EN
            chk("err_timeout", 64'(err_timeout), 64'(e_err));
`endif
        end
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) pulses[i]++;
            if (req_ready[i] && req_valid[i]) begin
                req_valid[i] = 1'b0;
            end else if (auto_left[i] > 0 && !req_valid[i]) begin
                issued[i]++;
                cx[i] = 32'h1000 * (i + 1) + issued[i];
                cy[i] = ~cx[i];
                req_valid[i] = 1'b1;
                auto_left[i]--;
            end
        end
        rr = m_req_valid && seen;
        case (dmode)
            1:       m_req_ready = rr;
            2:       m_req_ready = rr || last_r;
            default: m_req_ready = 1'b0;
        endcase
        last_r = rr;
        seen   = m_req_valid;
        m_z    = zforce ? 1'b1 : ^m_x;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_quiet(input string nm, input int budget);
        int t = 0;
        while ((auto_left[0] + auto_left[1] > 0 || req_valid != '0) && t < budget) begin
            step(1);
            t++;
        end
        total++;
        if (t >= budget) begin
            bad++;
            $display("FAIL %s: callers still busy after %0d cycles, want idle", nm, t);
        end
        step(2);
    endtask

    task automatic wait_pulse(input string nm, input int idx, input int base, input int budget);
        int t = 0;
        while (pulses[idx] == base && t < budget) begin
            step(1);
            t++;
        end
        chk(nm, 64'(pulses[idx] - base), 64'd1);
    endtask

    initial begin
        int p;
        int t;
        rst_n       = 1'b0;
        req_valid   = '0;
        m_req_ready = 1'b0;
        m_z         = 1'b0;
        dmode       = 1;
        zforce      = 1'b0;
        for (int i = 0; i < N; i++) begin
            cx[i] = '0;
            cy[i] = '0;
            auto_left[i] = 0;
            issued[i] = 0;
            pulses[i] = 0;
        end
        step(3);
        chk_en = 1'b1;
        chk("rst m_req_valid", 64'(m_req_valid), 64'd0);
        chk("rst req_ready", 64'(req_ready), 64'd0);
        chk("rst req_z", 64'(req_z), 64'd0);
        chk("rst m_x", 64'(m_x), 64'd0);
        rst_n = 1'b1;
        step(2);

        // Single call, registered downstream ready, z forced high.
        cx[0] = 32'd5;
        cy[0] = 32'd7;
        zforce = 1'b1;
        req_valid[0] = 1'b1;
        step(1);
        chk("single mv c1", 64'(m_req_valid), 64'd1);
        chk("single m_x c1", 64'(m_x), 64'd5);
        chk("single m_y c1", 64'(m_y), 64'd7);
        step(1);
        chk("single ready c2", 64'(req_ready), 64'd0);
        step(1);
        chk("single ready c3", 64'(req_ready), 64'b01);
        chk("single z c3", 64'(req_z), 64'b01);
        step(3);
        zforce = 1'b0;

        // Contention straight out of reset.
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        grants.delete();
        auto_left[0] = 2;
        auto_left[1] = 2;
        wait_quiet("contention", 200);
        chk("contention n", 64'(grants.size()), 64'd4);
        if (grants.size() == 4) begin
            chk("grant0", 64'(grants[0]), 64'd0);
            chk("grant1", 64'(grants[1]), 64'd1);
            chk("grant2", 64'(grants[2]), 64'd0);
            chk("grant3", 64'(grants[3]), 64'd1);
        end

        // Downstream ready lingers into the release cycle.
        dmode = 2;
        pulses[0] = 0;
        pulses[1] = 0;
        auto_left[0] = 1;
        auto_left[1] = 1;
        wait_quiet("lag", 200);
        chk("lag pulses0", 64'(pulses[0]), 64'd1);
        chk("lag pulses1", 64'(pulses[1]), 64'd1);
        dmode = 1;

        // Caller 1 withdraws mid-call; the committed call still completes.
        dmode = 0;
        cx[1] = 32'd7;
        cy[1] = 32'd3;
        req_valid[1] = 1'b1;
        p = pulses[1];
        step(1);
        chk("withdraw m_x", 64'(m_x), 64'd7);
        step(1);
        req_valid[1] = 1'b0;
        step(1);
        dmode = 1;
        wait_pulse("withdraw pulse", 1, p, 20);
        chk("withdraw z1", 64'(req_z[1]), 64'd1);
        step(3);
        chk("withdraw single", 64'(pulses[1] - p), 64'd1);

        // Reset while busy, then rotation restarts at caller 0.
        cx[0] = 32'd11;
        cy[0] = 32'd22;
        req_valid[0] = 1'b1;
        p = pulses[0];
        wait_pulse("pre-reset call", 0, p, 20);
        step(2);
        dmode = 0;
        cx[1] = 32'd33;
        cy[1] = 32'd44;
        req_valid[1] = 1'b1;
        step(1);
        chk("busy g1 m_x", 64'(m_x), 64'd33);
        step(1);
        rst_n = 1'b0;
        step(1);
        chk("midrst mv", 64'(m_req_valid), 64'd0);
        chk("midrst ready", 64'(req_ready), 64'd0);
        chk("midrst z", 64'(req_z), 64'd0);
        chk("midrst m_x", 64'(m_x), 64'd0);
        chk("midrst m_y", 64'(m_y), 64'd0);
        rst_n = 1'b1;
        req_valid[0] = 1'b1;
        dmode = 1;
        step(1);
        chk("postrst m_x", 64'(m_x), 64'd11);
        chk("postrst mv", 64'(m_req_valid), 64'd1);
        wait_quiet("postrst", 100);

`ifdef ARB_TIMEOUT_EN
        // Downstream never answers: watchdog aborts, next caller follows.
        dmode = 0;
        cx[0] = 32'd1;
        cx[1] = 32'd2;
        req_valid = 2'b11;
        t = 0;
        while (err_timeout == '0 && t < 40) begin
            step(1);
            t++;
        end
        chk("tmo err", 64'(err_timeout), 64'b01);
        chk("tmo ready", 64'(req_ready), 64'b01);
        chk("tmo latency", 64'(t), 64'd11);
        step(2);
        chk("tmo next m_x", 64'(m_x), 64'd2);
        chk("tmo next mv", 64'(m_req_valid), 64'd1);
        dmode = 1;
        wait_quiet("tmo drain", 100);
`else
        t = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

endmodule
